// File: rtl/spram_pkg.sv
// Shared constants and types for the 16K x 16 single-port SPRAM model.
package spram_pkg;

  localparam int SPRAM_DEPTH   = 16384;
  localparam int SPRAM_AW      = 14;
  localparam int SPRAM_DW      = 16;
  localparam int SPRAM_NIBBLES = 4;

  typedef logic [SPRAM_AW-1:0] spram_addr_t;
  typedef logic [SPRAM_DW-1:0] spram_word_t;

endpackage

// File: rtl/sb_spram256ka_if.sv
// Bus bundle for the SPRAM: address/data, nibble mask, access strobes,
// power controls and the registered read data.
interface sb_spram256ka_if;
  import spram_pkg::*;

  spram_addr_t                ADDRESS;
  spram_word_t                DATAIN;
  logic [SPRAM_NIBBLES-1:0]   MASKWREN;
  logic                       WREN;
  logic                       CHIPSELECT;
  logic                       STANDBY;
  logic                       SLEEP;
  logic                       POWEROFF;
  spram_word_t                DATAOUT;

  modport master (
    output ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    input  DATAOUT
  );

  modport slave (
    input  ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    output DATAOUT
  );
endinterface

// File: rtl/sb_spram256ka_nibble_merge.sv
// Combinational nibble merge: each nibble whose mask bit is set comes from
// the new data, the rest come from the old word. Shared by the array write
// path and the write-through read data path.
module spram_nibble_merge
  import spram_pkg::*;
(
  input  spram_word_t              old_word,
  input  spram_word_t              data_in,
  input  logic [SPRAM_NIBBLES-1:0] mask,
  output spram_word_t              merged_word
);

  // Replace only the enabled nibbles of the old word.
  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < SPRAM_NIBBLES; k++) begin
      if (mask[k]) begin
        merged_word[4*k +: 4] = data_in[4*k +: 4];
      end
    end
  end

endmodule

// File: rtl/sb_spram256ka.sv
// 16K x 16 single-port SPRAM with nibble write masks and low-power controls.
// Optional macro SPRAM_WRITE_THROUGH_EN: on a write cycle DATAOUT takes the
// merged word just written; without it DATAOUT holds during writes.
module sb_spram256ka
  import spram_pkg::*;
(
  input  logic           CLOCK,
  input  logic           rst_n,
  sb_spram256ka_if.slave bus
);

  spram_word_t mem [SPRAM_DEPTH];
  spram_word_t old_word;
  spram_word_t merged_word;
  spram_word_t dataout_q;
  logic        access_en;
  logic        write_en;
  logic        read_en;

  assign old_word = mem[bus.ADDRESS];

  spram_nibble_merge u_merge (
    .old_word    (old_word),
    .data_in     (bus.DATAIN),
    .mask        (bus.MASKWREN),
    .merged_word (merged_word)
  );

  // An access happens only when powered, awake, not in standby and selected.
  always_comb begin
    access_en = bus.POWEROFF & ~bus.SLEEP & ~bus.STANDBY & bus.CHIPSELECT;
    write_en  = access_en & bus.WREN;
    read_en   = access_en & ~bus.WREN;
  end

  // Array write port; independent of rst_n so loads continue during reset.
  // Contents are simply kept across power-off, which is one legal outcome
  // of the array being undefined after power is restored.
  always_ff @(posedge CLOCK) begin
    if (write_en) begin
      mem[bus.ADDRESS] <= merged_word;
    end
  end

  // Registered read data: cleared by reset, power-off and sleep, otherwise
  // updated only by an actual access.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      dataout_q <= '0;
    end else if (!bus.POWEROFF || bus.SLEEP) begin
      dataout_q <= '0;
    end else if (read_en) begin
      dataout_q <= old_word;
`ifdef SPRAM_WRITE_THROUGH_EN
    end else if (write_en) begin
      dataout_q <= merged_word;
`else
    end else begin
      dataout_q <= dataout_q;
`endif
    end
  end

  assign bus.DATAOUT = dataout_q;

endmodule

// File: tb/tb_sb_spram256ka.sv
// Directed self-checking bench for sb_spram256ka. Expected values are
// hand-computed; write-through expectations follow SPRAM_WRITE_THROUGH_EN.
module tb_sb_spram256ka;

  logic CLOCK;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  sb_spram256ka_if bus ();

  sb_spram256ka dut (
    .CLOCK (CLOCK),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Drive one access, then wait past the sampling edge.
  task automatic applyStimulus(input logic [13:0] addr, input logic [15:0] data,
                               input logic [3:0] mask, input logic wren,
                               input logic cs);
    bus.ADDRESS    = addr;
    bus.DATAIN     = data;
    bus.MASKWREN   = mask;
    bus.WREN       = wren;
    bus.CHIPSELECT = cs;
    @(posedge CLOCK);
    #1;
  endtask

  // Compare DATAOUT with the expected word.
  task automatic checkOutput(input string tag, input logic [15:0] expected);
    nCompared++;
    assert (bus.DATAOUT === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, bus.DATAOUT, expected);
    end
  endtask

  initial begin
    logic [15:0] wtExp;
    nCompared      = 0;
    nMismatched    = 0;
    rst_n          = 1'b0;
    bus.ADDRESS    = '0;
    bus.DATAIN     = '0;
    bus.MASKWREN   = '0;
    bus.WREN       = 1'b0;
    bus.CHIPSELECT = 1'b0;
    bus.STANDBY    = 1'b0;
    bus.SLEEP      = 1'b0;
    bus.POWEROFF   = 1'b1;

    repeat (2) @(posedge CLOCK);
    #1;
    checkOutput("reset_state", 16'h0000);
    rst_n = 1'b1;

    // Full-mask writes then reads at the address extremes and midpoint.
    applyStimulus(14'd0,     16'h0000 ^ 16'hA5A5, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd1,     16'h0001 ^ 16'hA5A5, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd8191,  16'h1FFF ^ 16'hA5A5, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd16383, 16'h3FFF ^ 16'hA5A5, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd0,     16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("read_addr0", 16'hA5A5);
    applyStimulus(14'd1,     16'h0000, 4'b1111, 1'b0, 1'b1);
    checkOutput("read_addr1", 16'hA5A4);
    applyStimulus(14'd8191,  16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("read_addr8191", 16'hBA5A);
    applyStimulus(14'd16383, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("read_addr16383", 16'h9A5A);

    // Nibble masking.
    applyStimulus(14'd5, 16'h1234, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd5, 16'hFFFF, 4'b0101, 1'b1, 1'b1);
    applyStimulus(14'd5, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("mask_0101", 16'h1F3F);
    applyStimulus(14'd5, 16'hFFFF, 4'b0000, 1'b1, 1'b1);
    applyStimulus(14'd5, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("mask_0000", 16'h1F3F);

    // Asynchronous reset mid-operation with DATAOUT = BEEF.
    applyStimulus(14'd10, 16'hBEEF, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd10, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("pre_reset_beef", 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", 16'h0000);
    applyStimulus(14'd10, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("reset_hold_read", 16'h0000);
    applyStimulus(14'd11, 16'h1111, 4'b1111, 1'b1, 1'b1);
    checkOutput("reset_hold_write", 16'h0000);
    bus.WREN = 1'b0;
    bus.ADDRESS = 14'd10;
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("reset_release_no_edge", 16'h0000);
    applyStimulus(14'd10, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("post_reset_read", 16'hBEEF);
    applyStimulus(14'd11, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("write_during_reset", 16'h1111);
    applyStimulus(14'd10, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("reread_beef", 16'hBEEF);

    // Gating: deselected and standby writes do nothing, DATAOUT holds.
    applyStimulus(14'd10, 16'h0000, 4'b1111, 1'b1, 1'b0);
    checkOutput("cs0_write_hold", 16'hBEEF);
    bus.STANDBY = 1'b1;
    applyStimulus(14'd10, 16'h0000, 4'b1111, 1'b1, 1'b1);
    checkOutput("standby_write_hold", 16'hBEEF);
    applyStimulus(14'd5, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("standby_read_hold", 16'hBEEF);
    bus.STANDBY = 1'b0;
    applyStimulus(14'd10, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("gated_contents_kept", 16'hBEEF);
    bus.SLEEP = 1'b1;
    applyStimulus(14'd5, 16'h0000, 4'b1111, 1'b1, 1'b1);
    checkOutput("sleep_zero", 16'h0000);
    bus.SLEEP = 1'b0;
    applyStimulus(14'd10, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("wake_read10", 16'hBEEF);
    applyStimulus(14'd5, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("wake_read5", 16'h1F3F);

    // Power-off for one cycle, then rewrite and read back.
    bus.POWEROFF = 1'b0;
    applyStimulus(14'd5, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("poweroff_zero", 16'h0000);
    bus.POWEROFF = 1'b1;
    applyStimulus(14'd7, 16'h0F0F, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd7, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("poweron_rw", 16'h0F0F);

    // Write-through behaviour.
    applyStimulus(14'd3, 16'h0000, 4'b1111, 1'b1, 1'b1);
    applyStimulus(14'd7, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("wt_setup", 16'h0F0F);
    applyStimulus(14'd3, 16'hCAFE, 4'b1111, 1'b1, 1'b1);
`ifdef SPRAM_WRITE_THROUGH_EN
    wtExp = 16'hCAFE;
`else
    wtExp = 16'h0F0F;
`endif
    checkOutput("wt_full_word", wtExp);
    applyStimulus(14'd5, 16'h00A0, 4'b0010, 1'b1, 1'b1);
`ifdef SPRAM_WRITE_THROUGH_EN
    wtExp = 16'h1FAF;
`else
    wtExp = 16'h0F0F;
`endif
    checkOutput("wt_merged", wtExp);
    applyStimulus(14'd3, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("read_cafe", 16'hCAFE);
    applyStimulus(14'd5, 16'h0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("read_merged5", 16'h1FAF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
